// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage: pipeline-register
// structs, access FSM states, opcode constants and default memory parameters.
package mips_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int MEM_LATENCY_DEFAULT = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_register;
    logic [31:0] branch_target;
    logic        zero;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_wb_t;

  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-addressed data memory: synchronous write, registered read captured on
// the enabled (access) edge. Contents are never reset; only the read register is.
module data_memory_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = re ? mem_q[addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata_q <= '0;
    else if (en) rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, branch resolution,
// multi-cycle data memory access and the MEM/WB register.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ex,
  input  logic [31:0] alu_result_ex,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register_ex,
  input  logic [31:0] branch_target_ex,
  input  logic        zero_ex,
  input  logic        ctrl_branch_ex,
  input  logic        ctrl_memRead_ex,
  input  logic        ctrl_memWrite_ex,
  input  logic        ctrl_regWrite_ex,
  input  logic        ctrl_memToReg_ex,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        misalign_err,
  output logic        valid_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_register_mem_wb,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb
);

  localparam int         ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT    = 4'(MEM_LATENCY);

  ex_mem_t    ex_mem_q, ex_mem_d;
  mem_wb_t    mem_wb_q, mem_wb_d;
  mem_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       misalign_q, misalign_d;

  logic              mem_op;
  logic              next_mem_op;
  logic              misaligned;
  logic              access;
  logic              store_en;
  logic              load_en;
  logic [ADDR_W-1:0] word_addr;

  always_comb begin
    mem_op      = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
    next_mem_op = valid_ex & (ctrl_memRead_ex | ctrl_memWrite_ex);
    stall       = (state_q == ST_WAIT) & (cnt_q != LAT);
    misaligned  = is_misaligned(ex_mem_q.alu_result[1:0]);
    access      = mem_op & ~stall;
    // A load+store combination is handled as a store.
    store_en    = access & ex_mem_q.mem_write & ~misaligned;
    load_en     = access & ex_mem_q.mem_read & ~ex_mem_q.mem_write & ~misaligned;
    word_addr   = ex_mem_q.alu_result[ADDR_W+1:2];
    pc_src      = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
  end

  always_comb begin
    ex_mem_d   = ex_mem_q;
    mem_wb_d   = mem_wb_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    if (stall) begin
      cnt_d             = cnt_q + 4'd1;
      mem_wb_d.valid     = 1'b0;
      mem_wb_d.reg_write = 1'b0;
    end else begin
      ex_mem_d = '{valid: valid_ex, alu_result: alu_result_ex, write_data: write_data_ex,
                   write_register: write_register_ex, branch_target: branch_target_ex,
                   zero: zero_ex, branch: ctrl_branch_ex, mem_read: ctrl_memRead_ex,
                   mem_write: ctrl_memWrite_ex, reg_write: ctrl_regWrite_ex,
                   mem_to_reg: ctrl_memToReg_ex};
      state_d  = (next_mem_op && (LAT != 4'd0)) ? ST_WAIT : ST_IDLE;
      cnt_d    = 4'd0;
      mem_wb_d.valid          = ex_mem_q.valid;
      mem_wb_d.alu_result     = ex_mem_q.alu_result;
      mem_wb_d.write_register = ex_mem_q.write_register;
      mem_wb_d.reg_write      = ex_mem_q.valid & ex_mem_q.reg_write & ~(mem_op & misaligned);
      mem_wb_d.mem_to_reg     = ex_mem_q.mem_to_reg;
      misalign_d              = access & misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      misalign_q <= 1'b0;
    end else begin
      ex_mem_q   <= ex_mem_d;
      mem_wb_q   <= mem_wb_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  data_memory_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .reset(reset),
    .en   (~stall),
    .we   (store_en),
    .re   (load_en),
    .addr (word_addr),
    .wdata(ex_mem_q.write_data),
    .rdata(read_data_mem_wb)
  );

  assign branch_target         = ex_mem_q.branch_target;
  assign misalign_err          = misalign_q;
  assign valid_mem_wb          = mem_wb_q.valid;
  assign alu_result_mem_wb     = mem_wb_q.alu_result;
  assign write_register_mem_wb = mem_wb_q.write_register;
  assign ctrl_regWrite_mem_wb  = mem_wb_q.reg_write;
  assign ctrl_memToReg_mem_wb  = mem_wb_q.mem_to_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: each issued instruction pushes its expected
// MEM/WB entry; a negedge monitor pops and compares whenever MEM/WB is valid.
module tb_memory_stage;
  import mips_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [31:0] alu_result_ex;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic [31:0] branch_target_ex;
  logic        zero_ex;
  logic        ctrl_branch_ex;
  logic        ctrl_memRead_ex;
  logic        ctrl_memWrite_ex;
  logic        ctrl_regWrite_ex;
  logic        ctrl_memToReg_ex;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        misalign_err;
  logic        valid_mem_wb;
  logic [31:0] read_data_mem_wb;
  logic [31:0] alu_result_mem_wb;
  logic [4:0]  write_register_mem_wb;
  logic        ctrl_regWrite_mem_wb;
  logic        ctrl_memToReg_mem_wb;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  bit          written   [DEPTH];
  int          vectors    = 0;
  int          miscompares = 0;

  memory_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .alu_result_ex(alu_result_ex),
    .write_data_ex(write_data_ex), .write_register_ex(write_register_ex),
    .branch_target_ex(branch_target_ex), .zero_ex(zero_ex), .ctrl_branch_ex(ctrl_branch_ex),
    .ctrl_memRead_ex(ctrl_memRead_ex), .ctrl_memWrite_ex(ctrl_memWrite_ex),
    .ctrl_regWrite_ex(ctrl_regWrite_ex), .ctrl_memToReg_ex(ctrl_memToReg_ex),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target), .misalign_err(misalign_err),
    .valid_mem_wb(valid_mem_wb), .read_data_mem_wb(read_data_mem_wb),
    .alu_result_mem_wb(alu_result_mem_wb), .write_register_mem_wb(write_register_mem_wb),
    .ctrl_regWrite_mem_wb(ctrl_regWrite_mem_wb), .ctrl_memToReg_mem_wb(ctrl_memToReg_mem_wb)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pop one expected entry per valid MEM/WB cycle; bubbles must not write.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (valid_mem_wb === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL wb_unexpected: got alu=%h rd=%0d with empty scoreboard",
                   alu_result_mem_wb, write_register_mem_wb);
        end else begin
          e = sb.pop_front();
          if ({alu_result_mem_wb, write_register_mem_wb, ctrl_regWrite_mem_wb,
               ctrl_memToReg_mem_wb, misalign_err} !== {e.alu, e.rd, e.rw, e.m2r, e.mis}) begin
            miscompares++;
            $display("[TB] FAIL wb_entry: got alu=%h rd=%0d rw=%b m2r=%b mis=%b, want alu=%h rd=%0d rw=%b m2r=%b mis=%b",
                     alu_result_mem_wb, write_register_mem_wb, ctrl_regWrite_mem_wb,
                     ctrl_memToReg_mem_wb, misalign_err, e.alu, e.rd, e.rw, e.m2r, e.mis);
          end
          if (e.chk_rd) begin
            vectors++;
            if (read_data_mem_wb !== e.rdata) begin
              miscompares++;
              $display("[TB] FAIL wb_read_data: got %h want %h (addr %h)",
                       read_data_mem_wb, e.rdata, e.alu);
            end
          end
        end
      end else begin
        vectors++;
        if ({ctrl_regWrite_mem_wb, misalign_err} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL wb_bubble: got regWrite=%b misalign=%b want 0 0",
                   ctrl_regWrite_mem_wb, misalign_err);
        end
      end
    end
  end

  task automatic drive_idle();
    valid_ex = 0; alu_result_ex = '0; write_data_ex = '0; write_register_ex = '0;
    branch_target_ex = '0; zero_ex = 0; ctrl_branch_ex = 0; ctrl_memRead_ex = 0;
    ctrl_memWrite_ex = 0; ctrl_regWrite_ex = 0; ctrl_memToReg_ex = 0;
  endtask

  // Called at a negedge: present one instruction, wait until accepted, push its expectation,
  // then count the stall cycles it causes. Returns at a negedge with valid_ex dropped.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] tgt, input logic zero,
                       output int stalls);
    exp_t e;
    int   n;
    int   w;
    logic is_mem;
    drive_idle();
    valid_ex = 1; alu_result_ex = alu; write_data_ex = wdata; write_register_ex = rd;
    branch_target_ex = tgt; zero_ex = zero;
    ctrl_memRead_ex  = (op == OP_LW);
    ctrl_memWrite_ex = (op == OP_SW);
    ctrl_branch_ex   = (op == OP_BEQ);
    ctrl_regWrite_ex = (op == OP_LW) || (op == OP_RTYPE);
    ctrl_memToReg_ex = (op == OP_LW);
    n = 0;
    while (stall === 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      vectors++; miscompares++;
      $display("[TB] FAIL issue_timeout: stall still %b after %0d cycles, want 0", stall, n);
    end
    @(posedge clk);
    is_mem   = ctrl_memRead_ex | ctrl_memWrite_ex;
    w        = int'(alu[9:2]);
    e.alu    = alu;
    e.rd     = rd;
    e.m2r    = ctrl_memToReg_ex;
    e.mis    = is_mem && (alu[1:0] != 2'b00);
    e.rw     = ctrl_regWrite_ex && !e.mis;
    e.chk_rd = (op == OP_LW) && !e.mis && written[w];
    e.rdata  = model_mem[w];
    if (op == OP_SW && !e.mis) begin model_mem[w] = wdata; written[w] = 1; end
    sb.push_back(e);
    @(negedge clk);
    valid_ex = 0;
    stalls = 0;
    while (stall === 1'b1 && stalls < 40) begin @(negedge clk); stalls++; end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stall, pc_src, branch_target, misalign_err, valid_mem_wb, read_data_mem_wb,
         alu_result_mem_wb, write_register_mem_wb, ctrl_regWrite_mem_wb,
         ctrl_memToReg_mem_wb} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: stall=%b valid=%b alu=%h rd=%h want all 0",
               stall, valid_mem_wb, alu_result_mem_wb, read_data_mem_wb);
    end
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({stall, valid_mem_wb, pc_src} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL after_reset: stall=%b valid=%b pc_src=%b want 0 0 0",
               stall, valid_mem_wb, pc_src);
    end
  endtask

  task automatic test_store_load();
    int s;
    issue(OP_SW, 32'h0000_0000, 32'hA5A5_0000, 5'd0, '0, 0, s);
    issue(OP_SW, 32'h0000_0020, 32'h1111_2222, 5'd0, '0, 0, s);
    issue(OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, '0, 0, s);
    vectors++;
    if (s != LAT) begin
      miscompares++; $display("[TB] FAIL sw_stall_cycles: got %0d want %0d", s, LAT);
    end
    issue(OP_LW, 32'h0000_0010, '0, 5'd8, '0, 0, s);
    vectors++;
    if (s != LAT) begin
      miscompares++; $display("[TB] FAIL lw_stall_cycles: got %0d want %0d", s, LAT);
    end
  endtask

  task automatic test_alu();
    int s;
    issue(OP_RTYPE, 32'h0000_0005, '0, 5'd3, '0, 0, s);
    vectors++;
    if (s != 0) begin
      miscompares++; $display("[TB] FAIL alu_stall: got %0d stall cycles want 0", s);
    end
  endtask

  task automatic test_misaligned();
    int s;
    issue(OP_LW, 32'h0000_0013, '0, 5'd7, '0, 0, s);
    vectors++;
    if (s != LAT) begin
      miscompares++; $display("[TB] FAIL misaligned_stall: got %0d want %0d", s, LAT);
    end
    issue(OP_SW, 32'h0000_0011, 32'hBAD0_BAD0, 5'd0, '0, 0, s);
    issue(OP_LW, 32'h0000_0010, '0, 5'd9, '0, 0, s);
  endtask

  task automatic test_branch();
    int s;
    issue(OP_BEQ, 32'h0, '0, 5'd0, 32'h0000_0040, 1, s);
    vectors++;
    if ({pc_src, branch_target} !== {1'b1, 32'h0000_0040}) begin
      miscompares++;
      $display("[TB] FAIL beq_taken: got pc_src=%b target=%h want 1 00000040", pc_src, branch_target);
    end
    @(negedge clk);
    vectors++;
    if (pc_src !== 1'b0) begin
      miscompares++; $display("[TB] FAIL beq_one_cycle: got pc_src=%b want 0", pc_src);
    end
    issue(OP_BEQ, 32'h4, '0, 5'd0, 32'h0000_0080, 0, s);
    vectors++;
    if ({pc_src, branch_target} !== {1'b0, 32'h0000_0080}) begin
      miscompares++;
      $display("[TB] FAIL beq_not_taken: got pc_src=%b target=%h want 0 00000080", pc_src, branch_target);
    end
  endtask

  task automatic test_back_to_back();
    int          s;
    int          kind;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 2);
      a    = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
      if (kind == 0) begin
        issue(OP_RTYPE, $urandom, '0, 5'($urandom_range(1, 31)), '0, 0, s);
        vectors++;
        if (s != 0) begin
          miscompares++; $display("[TB] FAIL b2b_alu_stall: got %0d want 0", s);
        end
      end else if (kind == 1) begin
        issue(OP_SW, a, $urandom, 5'd0, '0, 0, s);
      end else begin
        issue(OP_LW, a, '0, 5'($urandom_range(1, 31)), '0, 0, s);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int s;
    drive_idle();
    valid_ex = 1; alu_result_ex = 32'h20; write_data_ex = 32'h9999_9999; ctrl_memWrite_ex = 1;
    s = 0;
    while (stall === 1'b1 && s < 40) begin @(negedge clk); s++; end
    @(posedge clk);
    @(negedge clk);
    valid_ex = 0;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("[TB] FAIL mid_access_stall: got %b want 1", stall);
    end
    #1 reset = 0;
    #1;
    vectors++;
    if ({stall, valid_mem_wb, ctrl_regWrite_mem_wb} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_abort: stall=%b valid=%b regWrite=%b want 0 0 0",
               stall, valid_mem_wb, ctrl_regWrite_mem_wb);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_after_reset: stall=%b want 0", stall);
    end
    issue(OP_LW, 32'h0000_0020, '0, 5'd10, '0, 0, s);
    issue(OP_LW, 32'h0000_0400, '0, 5'd11, '0, 0, s);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; written[i] = 0; end
    test_reset();
    test_store_load();
    test_alu();
    test_misaligned();
    test_branch();
    test_back_to_back();
    test_reset_mid_access();
    repeat (6) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
